// File: rtl/booth_pkg.sv
// Shared types for the radix-4 Booth multiplier scheduler: FSM states,
// Booth digit operations and the triplet decoder.
package booth_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef enum logic [2:0] {
    ZERO = 3'd0,
    POS1 = 3'd1,
    POS2 = 3'd2,
    NEG1 = 3'd3,
    NEG2 = 3'd4
  } booth_op_t;

  // Triplet is {b[2k+1], b[2k], b[2k-1]}.
  function automatic booth_op_t booth_decode(input logic [2:0] triplet);
    booth_op_t op;
    case (triplet)
      3'b001, 3'b010: op = POS1;
      3'b011:         op = POS2;
      3'b100:         op = NEG2;
      3'b101, 3'b110: op = NEG1;
      default:        op = ZERO;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/booth_pp_gen.sv
// Combinational Booth partial-product generator: sign-extended, unshifted
// multiple of a selected by one radix-4 triplet.
module booth_pp_gen
  import booth_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0]   a,
  input  logic [2:0]         triplet,
  output logic [2*WIDTH-1:0] pp
);

  logic [2*WIDTH-1:0] a_ext;

  always_comb begin
    a_ext = {{WIDTH{a[WIDTH-1]}}, a};
    pp    = '0;
    case (booth_decode(triplet))
      POS1:    pp = a_ext;
      POS2:    pp = a_ext << 1;
      NEG1:    pp = -a_ext;
      NEG2:    pp = -(a_ext << 1);
      default: pp = '0;
    endcase
  end

endmodule

// File: rtl/booth_mul_scheduler.sv
// Two-requester round-robin front end sharing one sequential radix-4 Booth
// multiplier; one Booth digit retired per clock, results tagged by requester.
module booth_mul_scheduler
  import booth_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               req0_valid,
  output logic               req0_ready,
  input  logic [WIDTH-1:0]   req0_a,
  input  logic [WIDTH-1:0]   req0_b,
  input  logic               req1_valid,
  output logic               req1_ready,
  input  logic [WIDTH-1:0]   req1_a,
  input  logic [WIDTH-1:0]   req1_b,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic               rsp_id,
  output logic [2*WIDTH-1:0] rsp_p,
  output logic [1:0]         fsm_state
);

  // Handshakes: a transfer happens on a rising edge where valid && ready are
  // both high; requesters hold valid and operands until ready, and the
  // response holds rsp_valid/rsp_id/rsp_p until rsp_ready.

  localparam int DIGITS = WIDTH / 2;
  localparam int CW     = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  state_t             state;
  logic               last_grant;
  logic               grant;
  logic               accept;
  logic               id_q;
  logic [WIDTH-1:0]   a_q;
  logic [WIDTH:0]     b_sh;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] pp;
  logic [2*WIDTH-1:0] pp_shift;
  logic [CW-1:0]      cnt;

  // On a tie the requester that did not win last time is preferred.
  always_comb begin
    if (req0_valid && req1_valid) grant = ~last_grant;
    else                          grant = req1_valid;
  end

  assign req0_ready = !reset && (state == IDLE) && req0_valid && !grant;
  assign req1_ready = !reset && (state == IDLE) && req1_valid && grant;
  assign accept     = req0_ready | req1_ready;
  assign fsm_state  = state;

  // b_sh[2:0] always holds the current triplet; the appended 0 is b[-1].
  booth_pp_gen #(.WIDTH(WIDTH)) u_pp_gen (
    .a       (a_q),
    .triplet (b_sh[2:0]),
    .pp      (pp)
  );

  assign pp_shift = pp << {cnt, 1'b0};

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      rsp_valid  <= 1'b0;
      rsp_id     <= 1'b0;
      rsp_p      <= '0;
      acc        <= '0;
      cnt        <= '0;
      id_q       <= 1'b0;
      a_q        <= '0;
      b_sh       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            a_q        <= grant ? req1_a : req0_a;
            b_sh       <= {(grant ? req1_b : req0_b), 1'b0};
            id_q       <= grant;
            last_grant <= grant;
            acc        <= '0;
            cnt        <= '0;
            state      <= RUN;
          end
        end
        RUN: begin
          acc  <= acc + pp_shift;
          b_sh <= b_sh >> 2;
          cnt  <= cnt + 1'b1;
          if (cnt == CW'(DIGITS - 1)) begin
            rsp_valid <= 1'b1;
            rsp_p     <= acc + pp_shift;
            rsp_id    <= id_q;
            state     <= DONE;
          end
        end
        DONE: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/booth_mul_scheduler.md
# booth_mul_scheduler

Sequential radix-4 (modified) Booth multiplier with a two-requester round-robin front end. It sits between two client blocks that each need occasional signed 8x8 products and one shared multiplier datapath. It retires one Booth digit per clock, so an 8-bit operation takes four compute cycles. Results return on a single response channel tagged with the requester ID.

## Interface
- WIDTH, 8, operand width in bits; must be even, ≥ 4; product is 2*WIDTH bits
- clock  in  1  single clock, all state updates on rising edge
- reset  in  1  synchronous, active-high
- req0_valid  in  1  requester 0 has an operation pending
- req0_ready  out  1  requester 0 operands accepted this cycle
- req0_a, req0_b  in  WIDTH each  requester 0 signed two's-complement operands
- req1_valid / req1_ready / req1_a / req1_b  same as requester 0, for requester 1
- rsp_valid  out  1  result available
- rsp_ready  in  1  consumer accepts result
- rsp_id  out  1  requester that issued the result (0 or 1)
- rsp_p  out  2*WIDTH  signed product a*b

## Operation
- FSM states and transitions:
  - IDLE: grant if any reqN_valid → RUN.
  - RUN: WIDTH/2 cycles → DONE.
  - DONE: rsp_valid && rsp_ready → IDLE.
- Arbitration, in IDLE only:
  - One requester valid: it is granted.
  - Both valid: grant the requester not granted last (last_grant pointer).
  - reqN_ready = IDLE && grant==N; combinational, at most one high.
  - Transfer occurs on valid && ready.
- Accept edge:
  - Latch a, b and id.
  - Clear accumulator and digit counter.
  - Update last_grant.
- Each RUN edge, digit k = 0..WIDTH/2-1:
  - Triplet {b[2k+1], b[2k], b[2k-1]}, with b[-1] = 0.
  - Encoding: 000/111 → 0; 001/010 → +a; 011 → +2a; 100 → −2a; 101/110 → −a.
  - Partial product is sign-extended to 2*WIDTH bits, shifted left by 2k, and added to the accumulator modulo 2^(2*WIDTH).
- After the last digit, rsp_p = accumulator; the result is exact for all signed operand pairs.
- rsp_valid, rsp_id and rsp_p hold stable in DONE until accepted.
- Requester contract: valid and operands held stable until ready. Non-granted requesters wait; no request is dropped.

## Timing
- Reset values:
  - state IDLE; rsp_valid 0; rsp_id 0; rsp_p 0; accumulator 0.
  - last_grant = 1, so requester 0 wins the first tie.
  - req*_ready 0 while reset is high.
- Latency: rsp_valid rises exactly WIDTH/2 rising edges after the accepting edge (4 for WIDTH=8).
- Throughput: at most one accept per WIDTH/2 + 2 cycles (accept, RUN×WIDTH/2, DONE handshake). No accept is possible in the cycle a response is consumed; IDLE is re-entered on the following edge.
- rsp_ready may be held low indefinitely. The block stalls in DONE and all req*_ready stay 0.
- Reset mid-RUN or in DONE: the operation is discarded, no response is produced, and all reset values apply on the next edge.
- Valid deasserted by a non-granted requester before being granted: legal, nothing happens.

## Structure
- Package booth_pkg:
  - state enum (IDLE, RUN, DONE)
  - Booth op enum (ZERO, POS1, POS2, NEG1, NEG2)
  - function decoding a 3-bit triplet to an op
- Sub-module booth_pp_gen: combinational; inputs a (WIDTH) and triplet (3); output sign-extended 2*WIDTH-bit partial product, unshifted.
- Top-level content: arbiter, FSM, operand/ID registers, digit counter, accumulator.

## Test plan
- Single request: req0 a=7, b=3 → req0_ready for one cycle; rsp_valid 4 edges later with rsp_id=0, rsp_p=0x0015.
- Tie after reset: req0 (5×6) and req1 (−3×4) valid together → rsp_id=0 first with p=0x001E, then rsp_id=1 with p=0xFFF4. Repeated ties alternate 0,1,0,1.
- Corners:
  - −128×−128 → 0x4000
  - 127×−128 → 0xC080
  - −1×−1 → 0x0001
  - 0×−128 → 0x0000
  - −128×127 → 0xC080
- Backpressure: rsp_ready low for 10 cycles while req1 is valid → rsp_p and rsp_id stable, req1_ready stays 0. Raise rsp_ready → req1 accepted two edges later.
- Reset asserted on the 2nd RUN cycle of 9×9 → no rsp_valid. A following 2×−3 yields 0xFFFA with the correct latency.
- Exhaustive: all 65536 operand pairs through alternating requesters, compared against a signed reference model; latency checked on every transaction.
